y_input_conditioner: RTL and testbench

Input conditioning stage directly upstream of the microcoded dispatch sequencer. Takes the asynchronous 2-bit branch-select input, synchronises and debounces it, and presents a stable `y` to the sequencer. A `hold` input freezes `y` while the sequencer is in a dispatch state, so the branch decision never sees a mid-cycle change.

---
 rtl/y_cond_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 37 +++
 rtl/y_input_conditioner.sv | 179 +++++++++++++++++
 tb/tb_y_input_conditioner.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/y_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module  : y_cond_pkg
// Purpose : Shared types and constants for the y_input_conditioner block:
//           debounce FSM state encoding, synchroniser depth and the default
//           debounce length.
// Ports   : none (package)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
package y_cond_pkg;

    // Debounce FSM states. SETTLING is the reset state so that the reset
    // value of the candidate (0) qualifies through the normal path.
    typedef enum logic [1:0] {
        ST_SETTLING = 2'd0,
        ST_IDLE     = 2'd1,
        ST_PENDING  = 2'd2
    } state_e;

    localparam int SYNC_STAGES      = 2;
    localparam int DEBOUNCE_DEFAULT = 4;

endpackage : y_cond_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_2ff
// Purpose : Single-bit two-flop synchroniser with synchronous reset. Brings an
//           asynchronous input into the clk domain; only the last stage may be
//           used by downstream logic.
// Ports   : clk_i - clock, rising edge
//           rst_i - synchronous active-high reset (all stages to 0)
//           d_i   - asynchronous input bit
//           q_o   - synchronised output (last stage)
// Config  : none
// Revision: 1.0 - initial release
// ============================================================================
module sync_2ff
    import y_cond_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    // Bit 0 is the first (metastability-exposed) stage.
    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule : sync_2ff
`default_nettype wire

// File: rtl/y_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : y_input_conditioner
// Purpose : Synchronises and debounces the asynchronous branch-select input
//           and presents a stable y to the dispatch sequencer. While hold is
//           high, a qualified value waits in PENDING so y never changes
//           during a dispatch state.
// Ports   : clk        - clock, rising edge
//           reset      - synchronous active-high reset
//           y_raw      - asynchronous branch-select input [WIDTH]
//           hold       - freezes y while high
//           y          - debounced, stable select [WIDTH]
//           y_valid    - high once a value has been accepted after reset
//           y_change   - one-cycle pulse when y takes a new, different value
//           glitch_cnt - aborted-candidate count [GCNT_W] (optional)
// Config  : Y_GLITCH_COUNT_EN - when defined, adds the glitch_cnt port and
//           its saturating counter.
// Revision: 1.0 - initial release
// ============================================================================
module y_input_conditioner
    import y_cond_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int DEBOUNCE = DEBOUNCE_DEFAULT,
    parameter int GCNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  y_raw,
    input  logic              hold,
    output logic [WIDTH-1:0]  y,
    output logic              y_valid,
`ifdef Y_GLITCH_COUNT_EN
    output logic [GCNT_W-1:0] glitch_cnt,
`endif
    output logic              y_change
);

    // Parameter legality is checked at elaboration.
    generate
        if (DEBOUNCE < 1 || DEBOUNCE > 255 || GCNT_W < 1 || WIDTH < 1) begin : g_bad_param
            $error("y_input_conditioner: illegal parameter value");
        end
    endgenerate

    localparam logic [7:0] c_cnt_last = 8'(DEBOUNCE - 1);

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_sync2;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
            sync_2ff u_sync (
                .clk_i (clk),
                .rst_i (reset),
                .d_i   (y_raw[gi]),
                .q_o   (w_sync2[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Debounce FSM, counter and output registers
    // ------------------------------------------------------------------
    state_e           state_q,    state_d;
    logic [WIDTH-1:0] cand_q,     cand_d;
    logic [7:0]       cnt_q,      cnt_d;
    logic [WIDTH-1:0] y_q,        y_d;
    logic             y_valid_q,  y_valid_d;
    logic             y_change_q, y_change_d;
    logic             w_restart;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_SETTLING;
            cand_q     <= '0;
            cnt_q      <= '0;
            y_q        <= '0;
            y_valid_q  <= 1'b0;
            y_change_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            cnt_q      <= cnt_d;
            y_q        <= y_d;
            y_valid_q  <= y_valid_d;
            y_change_q <= y_change_d;
        end
    end

    always_comb begin
        logic accept;
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        y_d        = y_q;
        y_valid_d  = y_valid_q;
        y_change_d = 1'b0;
        w_restart  = 1'b0;
        accept     = 1'b0;

        if (w_sync2 != cand_q) begin
            // A new synchronised value restarts qualification from any
            // state; this also discards a value waiting in PENDING.
            w_restart = 1'b1;
            cand_d    = w_sync2;
            cnt_d     = '0;
            state_d   = ST_SETTLING;
        end else begin
            case (state_q)
                ST_SETTLING: begin
                    if (cnt_q < c_cnt_last) begin
                        cnt_d = cnt_q + 8'd1;
                    end else if (!hold) begin
                        accept  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (!hold) begin
                        accept  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    // IDLE: y already reflects the candidate.
                end
            endcase
        end

        if (accept) begin
            y_d        = cand_q;
            y_valid_d  = 1'b1;
            // First acceptance after reset always pulses, even for value 0.
            y_change_d = (cand_q != y_q) || !y_valid_q;
        end
    end

    assign y        = y_q;
    assign y_valid  = y_valid_q;
    assign y_change = y_change_q;

`ifdef Y_GLITCH_COUNT_EN
    // ------------------------------------------------------------------
    // Glitch counter: counts candidates abandoned part-way through
    // qualification or while waiting for hold to drop. A restart from
    // IDLE, or from SETTLING before any counting, is a normal change.
    // ------------------------------------------------------------------
    logic [GCNT_W-1:0] glitch_q, glitch_d;
    logic              w_glitch;

    assign w_glitch = w_restart &&
                      (((state_q == ST_SETTLING) && (cnt_q != 8'd0)) ||
                       (state_q == ST_PENDING));

    always_comb begin
        glitch_d = glitch_q;
        if (w_glitch && (glitch_q != {GCNT_W{1'b1}})) begin
            glitch_d = glitch_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule : y_input_conditioner
`default_nettype wire

// File: tb/tb_y_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module  : tb_y_input_conditioner
// Purpose : Self-checking bench for y_input_conditioner (DEBOUNCE=4). Stimulus
//           pushes the expected (value, edge number) of every y_change pulse
//           into a queue; a monitor pops and compares each pulse the DUT
//           produces. Edge numbers count rising clock edges since time 0.
// Config  : Y_GLITCH_COUNT_EN - also checks glitch_cnt when defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_y_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] y_raw;
    logic       hold;
    logic [1:0] y;
    logic       y_valid;
    logic       y_change;
`ifdef Y_GLITCH_COUNT_EN
    logic [7:0] glitch_cnt;
`endif

    y_input_conditioner #(
        .WIDTH    (2),
        .DEBOUNCE (4),
        .GCNT_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .y_raw      (y_raw),
        .hold       (hold),
        .y          (y),
        .y_valid    (y_valid),
`ifdef Y_GLITCH_COUNT_EN
        .glitch_cnt (glitch_cnt),
`endif
        .y_change   (y_change)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] val;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [1:0] v, input int at);
        exp_t e;
        e.val = v;
        e.at  = at;
        exp_q.push_back(e);
    endtask

    // Monitor: every y_change pulse must match the next expectation.
    always @(negedge clk) begin
        if (y_change === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: y_change high with y=%0h at edge %0d, none expected", y, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_value", 32'(y), 32'(e.val));
                check("pulse_edge", 32'(cyc), 32'(e.at));
                check("pulse_valid", 32'(y_valid), 32'd1);
            end
        end
    end

    int n, k, m, r;

    initial begin
        reset = 1'b1;
        y_raw = 2'b00;
        hold  = 1'b0;
        step(3);

        // Reset state
        check("rst_y", 32'(y), 32'd0);
        check("rst_valid", 32'(y_valid), 32'd0);
        check("rst_change", 32'(y_change), 32'd0);
`ifdef Y_GLITCH_COUNT_EN
        check("rst_glitch", 32'(glitch_cnt), 32'd0);
`endif

        // Value 0 after reset: candidate already equals sync2, so counting
        // starts on the first edge with reset low (cnt 1,2,3) and the
        // accept lands on the fourth.
        r = cyc;
        reset = 1'b0;
        expect_pulse(2'b00, r + 4);
        step(8);

        // 00 -> 10, hold low: stable from edge n+1, accepted at n+1+6.
        n = cyc;
        y_raw = 2'b10;
        expect_pulse(2'b10, n + 7);
        step(10);

        // 2-cycle bounce to 01 and back: no pulse, y stays 10.
        y_raw = 2'b01;
        step(2);
        y_raw = 2'b10;
        step(10);
        check("bounce_y", 32'(y), 32'h2);
`ifdef Y_GLITCH_COUNT_EN
        check("bounce_glitch", 32'(glitch_cnt), 32'd1);
`endif

        // hold high through a change to 11, released after edge k+10.
        n = cyc;
        k = n + 1;
        hold  = 1'b1;
        y_raw = 2'b11;
        step(11);
        check("held_y", 32'(y), 32'h2);
        hold = 1'b0;
        expect_pulse(2'b11, k + 11);
        step(6);

        // 10 waits in PENDING, then input moves to 01: 10 is dropped,
        // 01 accepted 6 edges after it becomes stable.
        hold  = 1'b1;
        y_raw = 2'b10;
        step(10);
        m = cyc;
        y_raw = 2'b01;
        step(3);
        check("pending_drop_y", 32'(y), 32'h3);
        hold = 1'b0;
        expect_pulse(2'b01, m + 7);
        step(8);
`ifdef Y_GLITCH_COUNT_EN
        check("pending_glitch", 32'(glitch_cnt), 32'd2);
`endif

        // Reset mid-SETTLING.
        n = cyc;
        y_raw = 2'b10;
        step(4);
        reset = 1'b1;
        step(1);
        check("midrst_y", 32'(y), 32'd0);
        check("midrst_valid", 32'(y_valid), 32'd0);
        check("midrst_change", 32'(y_change), 32'd0);
`ifdef Y_GLITCH_COUNT_EN
        check("midrst_glitch", 32'(glitch_cnt), 32'd0);
`endif
        r = cyc;
        reset = 1'b0;
        // Sync chain refills (r+1, r+2), restart at r+3, accept at r+7.
        expect_pulse(2'b10, r + 7);
        step(12);
        check("final_y", 32'(y), 32'h2);
`ifdef Y_GLITCH_COUNT_EN
        // Restart at r+3 happened in SETTLING with cnt=2.
        check("final_glitch", 32'(glitch_cnt), 32'd1);
`endif

        check("missing_pulses", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_y_input_conditioner
`default_nettype wire
